// File: rtl/mixrx1_if.sv
// mixrx1_if: sample/frequency inputs and I/Q result bundle for the mixrx1 receive mixer.
// master drives the ADC stream and LO control; slave is the mixer itself.
interface mixrx1_if;
    logic [31:0] phi;
    logic        phase_clr;
    logic        adc_valid;
    logic [11:0] adc;
    logic [17:0] i_result;
    logic [17:0] q_result;
    logic        out_valid;

    modport master (
        output phi,
        output phase_clr,
        output adc_valid,
        output adc,
        input  i_result,
        input  q_result,
        input  out_valid
    );

    modport slave (
        input  phi,
        input  phase_clr,
        input  adc_valid,
        input  adc,
        output i_result,
        output q_result,
        output out_valid
    );
endinterface

// File: rtl/mixrx1.sv
// mixrx1: receive downconversion mixer, real 12-bit ADC times a quadrature LO -> 18-bit I/Q, 4-edge latency.
// Build macro MIXRX_RAND_EN: decode output-randomized ADC codes in stage 1 (default: plain two's complement).
module mixrx1 (
    input  logic    clk,
    input  logic    rst,
    mixrx1_if.slave bus
);
    localparam real                PI       = 3.14159265358979323846;
    localparam real                AMP      = 131071.0;
    localparam logic signed [29:0] RND_HALF = 30'sd1024;

    // Half-bin offset keeps every entry strictly positive and makes the quarter symmetric.
    function automatic logic [17:0] quarter_sine(input int k);
        real ang;
        ang = 2.0 * PI * (real'(k) + 0.5) / 1024.0;
        return 18'($rtoi(AMP * $sin(ang) + 0.5));
    endfunction

    logic [17:0] sine_rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign sine_rom[gi] = quarter_sine(gi);
    end

    // Phase accumulator and stage 1: sample, quadrant and table index
    logic [31:0]        acc_q,    acc_d;
    logic               s1_vld_q, s1_vld_d;
    logic signed [11:0] s1_adc_q, s1_adc_d;
    logic [1:0]         s1_qd_q,  s1_qd_d;
    logic [7:0]         s1_x_q,   s1_x_d;
    logic [11:0]        adc_dec;

    // Stage 2: folded LO
    logic               s2_vld_q, s2_vld_d;
    logic signed [11:0] s2_adc_q, s2_adc_d;
    logic signed [17:0] s2_sin_q, s2_sin_d;
    logic signed [17:0] s2_cos_q, s2_cos_d;
    logic [7:0]         sin_idx;
    logic [7:0]         cos_idx;
    logic [17:0]        sin_mag;
    logic [17:0]        cos_mag;

    // Stage 3: full-precision products
    logic               s3_vld_q, s3_vld_d;
    logic signed [29:0] s3_i_q,   s3_i_d;
    logic signed [29:0] s3_q_q,   s3_q_d;

    // Stage 4: rounded results, then the output register
    logic               s4_vld_q, s4_vld_d;
    logic signed [17:0] s4_i_q,   s4_i_d;
    logic signed [17:0] s4_q_q,   s4_q_d;
    logic signed [29:0] i_sum;
    logic signed [29:0] q_sum;
    logic               rnd_unused;

    logic               out_vld_q, out_vld_d;
    logic signed [17:0] out_i_q,   out_i_d;
    logic signed [17:0] out_q_q,   out_q_d;

    always_comb begin
`ifdef MIXRX_RAND_EN
        adc_dec = {bus.adc[11:1] ^ {11{bus.adc[0]}}, bus.adc[0]};
`else
        adc_dec = bus.adc;
`endif
    end

    // The incoming sample is paired with the accumulator value before this cycle's update.
    always_comb begin
        acc_d = acc_q;
        if (bus.phase_clr) begin
            acc_d = '0;
        end else if (bus.adc_valid) begin
            acc_d = acc_q + bus.phi;
        end
        s1_vld_d = bus.adc_valid;
        s1_adc_d = adc_dec;
        s1_qd_d  = acc_q[31:30];
        s1_x_d   = acc_q[29:22];
    end

    // Odd quadrants mirror the index; sin is negative in the lower half, cos in quadrants 1 and 2.
    always_comb begin
        sin_idx  = s1_qd_q[0] ? ~s1_x_q : s1_x_q;
        cos_idx  = s1_qd_q[0] ? s1_x_q : ~s1_x_q;
        sin_mag  = sine_rom[sin_idx];
        cos_mag  = sine_rom[cos_idx];
        s2_sin_d = s1_qd_q[1] ? -$signed(sin_mag) : $signed(sin_mag);
        s2_cos_d = (^s1_qd_q) ? -$signed(cos_mag) : $signed(cos_mag);
        s2_adc_d = s1_adc_q;
        s2_vld_d = s1_vld_q;
    end

    always_comb begin
        s3_i_d   = 30'(s2_adc_q) * 30'(s2_cos_q);
        s3_q_d   = 30'(s2_adc_q) * 30'(s2_sin_q);
        s3_vld_d = s2_vld_q;
    end

    // Products stay within +/-2^28, so adding half an LSB cannot overflow and no saturation is needed.
    always_comb begin
        i_sum      = s3_i_q + RND_HALF;
        q_sum      = s3_q_q + RND_HALF;
        s4_i_d     = i_sum[28:11];
        s4_q_d     = q_sum[28:11];
        s4_vld_d   = s3_vld_q;
        rnd_unused = ^{i_sum[29], i_sum[10:0], q_sum[29], q_sum[10:0]};
    end

    always_comb begin
        out_i_d   = s4_i_q;
        out_q_d   = s4_q_q;
        out_vld_d = s4_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_adc_q  <= '0;
            s1_qd_q   <= '0;
            s1_x_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_adc_q  <= '0;
            s2_sin_q  <= '0;
            s2_cos_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_i_q    <= '0;
            s3_q_q    <= '0;
            s4_vld_q  <= 1'b0;
            s4_i_q    <= '0;
            s4_q_q    <= '0;
            out_vld_q <= 1'b0;
            out_i_q   <= '0;
            out_q_q   <= '0;
        end else begin
            acc_q     <= acc_d;
            s1_vld_q  <= s1_vld_d;
            s1_adc_q  <= s1_adc_d;
            s1_qd_q   <= s1_qd_d;
            s1_x_q    <= s1_x_d;
            s2_vld_q  <= s2_vld_d;
            s2_adc_q  <= s2_adc_d;
            s2_sin_q  <= s2_sin_d;
            s2_cos_q  <= s2_cos_d;
            s3_vld_q  <= s3_vld_d;
            s3_i_q    <= s3_i_d;
            s3_q_q    <= s3_q_d;
            s4_vld_q  <= s4_vld_d;
            s4_i_q    <= s4_i_d;
            s4_q_q    <= s4_q_d;
            out_vld_q <= out_vld_d;
            out_i_q   <= out_i_d;
            out_q_q   <= out_q_d;
        end
    end

    assign bus.i_result  = out_i_q;
    assign bus.q_result  = out_q_q;
    assign bus.out_valid = out_vld_q;
endmodule

// File: doc/mixrx1.md
# mixrx1

Receive-path digital downconversion mixer: multiplies the real 12-bit ADC sample stream by an internally generated quadrature local oscillator and delivers 18-bit signed I/Q at ADC rate. It sits between the ADC capture register and the receive CIC decimators. It is the receive-side counterpart of the transmit upconversion mixer. It contains its own 32-bit phase accumulator and a quarter-wave sine table, fully pipelined at one sample per clock.

## Interface

- No parameters; all widths are fixed.
- clk  in  1  sample clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- phi  in  32  frequency word, unsigned; f_LO = phi·f_clk/2^32; sampled every cycle.
- phase_clr  in  1  zeroes the phase accumulator.
- adc_valid  in  1  sample strobe for adc.
- adc  in  12  signed ADC sample (raw randomized code when MIXRX_RAND_EN).
- i_result  out  18  signed in-phase output.
- q_result  out  18  signed quadrature output.
- out_valid  out  1  i_result/q_result valid this cycle.

## Operation

- Phase accumulator acc[31:0]:
  - On adc_valid, acc <= acc + phi (mod 2^32).
  - phase_clr has priority and forces acc <= 0, regardless of adc_valid.
  - The sample presented with adc_valid is mixed with the acc value held in that same cycle, i.e. before the update.
- Table S[k], k = 0..255: S[k] = round(131071·sin(2π(k+0.5)/1024)), 18-bit. Entries are positive, S[0]=402 and S[255]=131070.
- Lookup: quadrant qd = acc[31:30], index x = acc[29:22]; acc[21:0] is truncated with no dither. Per quadrant:
  - qd=0: sin = S[x], cos = S[255−x]
  - qd=1: sin = S[255−x], cos = −S[x]
  - qd=2: sin = −S[x], cos = −S[255−x]
  - qd=3: sin = −S[255−x], cos = S[x]
- Mixing: i = adc·cos and q = adc·sin, each a 30-bit signed product. The sign convention is q = +adc·sin; the downstream stages absorb the sign.
- Rounding: result = (product + 2^10) >>> 11, round-half-up, keeping the low 18 bits.
  - |cos|,|sin| ≤ 131071 and adc ≥ −2048, so the magnitude never exceeds 131071.
  - No saturation logic is required.
- adc is delayed internally to align with the table output. Every pipeline stage carries a valid bit; gaps in adc_valid propagate unchanged to out_valid.

## Timing

- Latency: a sample with adc_valid at edge n produces out_valid=1 with its result after edge n+4.
- Pipeline stages:
  1. Capture the sample and quadrant/index.
  2. Table read plus sign fold.
  3. Multiply.
  4. Round, then output register.
- Throughput: one sample per clock, with no backpressure.
- Reset, applied on any edge while rst=1:
  - acc, every pipeline data/valid register, i_result, q_result and out_valid go to 0.
  - Reset mid-stream discards all in-flight samples; out_valid stays 0 until 4 edges after the first post-reset adc_valid.
- A change of phi takes effect on the next accumulator update and produces no glitch in samples already in flight.
- phase_clr with adc_valid in the same cycle: that sample uses the old acc; the next sample uses acc = 0.
- Accumulator wrap at 2^32 is silent modular arithmetic.

## Configuration

- MIXRX_RAND_EN defined: adc is treated as output-randomized code. The block decodes adc_d = {adc[11:1] ^ {11{adc[0]}}, adc[0]} in stage 1, before mixing.
- MIXRX_RAND_EN undefined: adc is used directly as two's complement, and there is no extra logic. Latency is identical in both builds.

## Test plan

- Reset/DC: rst high then low, phi=0, adc=1000 with continuous adc_valid.
  - During reset and for the first 4 edges: i_result=q_result=0 and out_valid=0.
  - Afterwards: i_result=63999, q_result=196 steady.
- fs/4: phi=32'h4000_0000, adc=−2048 continuous from acc=0.
  - i_result sequence: −131070, 402, 131070, −402 (repeating).
  - q_result sequence: −402, −131070, 402, 131070 (repeating).
- Valid gaps: adc_valid pattern 1,0,0,1,1 with phi=2^30.
  - out_valid reproduces 1,0,0,1,1 four cycles later.
  - acc advances only on strobed cycles, giving quadrants 0,1,2 on the three valid outputs.
- phase_clr: run phi=2^30 for 3 samples, then assert phase_clr together with adc_valid.
  - That sample uses quadrant 3.
  - The next sample uses quadrant 0 (cos=131070).
- Mid-stream reset: assert rst for 1 cycle while 3 samples are in flight.
  - No out_valid pulses for those samples.
  - acc restarts at 0.
- MIXRX_RAND_EN build: adc=12'h003, phi=0.
  - Decoded value is −3.
  - i_result = round(−3·131070/2048) = −192; q_result = −1.
